// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: op encodings, exception codes,
// FSM state type and the byte-lane / alignment helpers.
package mem_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LHU  = 4'd3;
  localparam logic [3:0] OP_LB   = 4'd4;
  localparam logic [3:0] OP_LBU  = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SB   = 4'd8;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_load_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return is_load_op(op) || is_store_op(op);
  endfunction

  // Byte enables for an access of the op's size starting at byte lane 'lane'
  // (up to 8 lanes; narrower buses use the low bits).
  function automatic logic [7:0] lane_mask(input logic [3:0] op, input logic [2:0] lane);
    logic [7:0] base;
    case (op)
      OP_LW, OP_SW:         base = 8'h0F;
      OP_LH, OP_LHU, OP_SH: base = 8'h03;
      OP_LB, OP_LBU, OP_SB: base = 8'h01;
      default:              base = 8'h00;
    endcase
    return base << lane;
  endfunction

  // Words must be 4-byte aligned, halves 2-byte aligned; bytes never fault.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    logic mis;
    case (op)
      OP_LW, OP_SW:         mis = (addr_lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: mis = addr_lo[0];
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data path: picks the addressed bytes out of the memory bus word and
// sign- or zero-extends them to 32 bits.
module mem_load_ext
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [3:0]        op,
  input  logic [LANE_W-1:0] lane,
  input  logic [DATA_W-1:0] rdata,
  output logic [31:0]       ext_val
);

  logic [DATA_W-1:0] shifted_s;

  // Align the addressed byte to bit 0, then extend according to the op.
  always_comb begin
    shifted_s = rdata >> {lane, 3'b000};
    case (op)
      OP_LW:   ext_val = shifted_s[31:0];
      OP_LH:   ext_val = {{16{shifted_s[15]}}, shifted_s[15:0]};
      OP_LHU:  ext_val = {16'h0000, shifted_s[15:0]};
      OP_LB:   ext_val = {{24{shifted_s[7]}}, shifted_s[7:0]};
      OP_LBU:  ext_val = {24'h000000, shifted_s[7:0]};
      default: ext_val = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with a req/ack handshake to variable-latency data
// memory. Holds the pipeline with 'stall' while an access is outstanding,
// flags misaligned accesses and registers the MEM/WB result.
module mem_stage_hs
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NUM_FWD = 4,
  parameter int REG_W   = 5,
  parameter int SEL_W   = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [3:0]            in_op,
  input  logic [ADDR_W-1:0]     in_alu,
  input  logic [NUM_FWD*32-1:0] in_fwd_data,
  input  logic [SEL_W-1:0]      in_fwd_sel,
  input  logic [REG_W-1:0]      in_a3,
  input  logic [31:0]           in_pc,
  output logic                  stall,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [ADDR_W-1:0]     dm_addr,
  output logic [DATA_W/8-1:0]   dm_be,
  output logic [DATA_W-1:0]     dm_wdata,
  input  logic                  dm_ack,
  input  logic [DATA_W-1:0]     dm_rdata,
  output logic                  out_valid,
  output logic [31:0]           out_result,
  output logic [REG_W-1:0]      out_a3,
  output logic [31:0]           out_pc,
  output logic [1:0]            out_exc
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_result_q, out_result_d;
  logic [REG_W-1:0]   out_a3_q, out_a3_d;
  logic [31:0]        out_pc_q, out_pc_d;
  logic [1:0]         out_exc_q, out_exc_d;

  logic [LANE_W-1:0]  lane_s;
  logic               mis_s;
  logic               go_s;
  logic [7:0]         be_full_s;
  logic [31:0]        st_word_s;
  logic [31:0]        load_val_s;
  logic [31:0]        fwd_slot_s [NUM_FWD];

  for (genvar g = 0; g < NUM_FWD; g++) begin : g_fwd
    assign fwd_slot_s[g] = in_fwd_data[32*g +: 32];
  end

  mem_load_ext #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_load_ext (
    .op      (in_op),
    .lane    (lane_s),
    .rdata   (dm_rdata),
    .ext_val (load_val_s)
  );

  // Decode the incoming instruction: lane, alignment and whether to start an access.
  always_comb begin
    lane_s    = in_alu[LANE_W-1:0];
    mis_s     = is_misaligned(in_op, in_alu[1:0]);
    go_s      = in_valid & is_mem_op(in_op) & ~mis_s;
    be_full_s = lane_mask(in_op, 3'(lane_s));
    st_word_s = fwd_slot_s[in_fwd_sel];
  end

  // Memory bus: request held through BUSY; reset drops it so an abandoned access stays abandoned.
  always_comb begin
    dm_req  = ~reset & ((state_q == ST_BUSY) | go_s);
    dm_we   = dm_req & is_store_op(in_op);
    dm_addr = {in_alu[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
    stall   = dm_req & ~dm_ack;
    if (dm_req) begin
      dm_be = be_full_s[NB-1:0];
    end else begin
      dm_be = {NB{1'b0}};
    end
    case (in_op)
      OP_SW:   dm_wdata = {(DATA_W/32){st_word_s}};
      OP_SH:   dm_wdata = {(NB/2){st_word_s[15:0]}};
      OP_SB:   dm_wdata = {NB{st_word_s[7:0]}};
      default: dm_wdata = {DATA_W{1'b0}};
    endcase
  end

  // Handshake FSM next state: wait in BUSY until the memory acknowledges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (go_s && !dm_ack) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (dm_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // MEM/WB next value: bubble when idle or stalled, otherwise the completed instruction.
  always_comb begin
    out_valid_d  = 1'b0;
    out_result_d = out_result_q;
    out_a3_d     = {REG_W{1'b0}};
    out_pc_d     = out_pc_q;
    out_exc_d    = out_exc_q;
    if (in_valid && !stall) begin
      out_valid_d  = 1'b1;
      out_pc_d     = in_pc;
      out_result_d = 32'(in_alu);
      out_exc_d    = EXC_NONE;
      if (mis_s) begin
        out_exc_d = is_store_op(in_op) ? EXC_ADES : EXC_ADEL;
      end else if (is_load_op(in_op)) begin
        out_result_d = load_val_s;
        out_a3_d     = in_a3;
      end else if (is_store_op(in_op)) begin
        out_a3_d = {REG_W{1'b0}};
      end else begin
        out_a3_d = in_a3;
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // State and MEM/WB registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= 32'h0000_0000;
      out_a3_q     <= {REG_W{1'b0}};
      out_pc_q     <= 32'h0000_0000;
      out_exc_q    <= EXC_NONE;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_a3_q     <= out_a3_d;
      out_pc_q     <= out_pc_d;
      out_exc_q    <= out_exc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_a3     = out_a3_q;
  assign out_pc     = out_pc_q;
  assign out_exc    = out_exc_q;

endmodule
